// File: rtl/pic24_read_seq.sv
// PIC24 program-memory block reader: turns (addr, count) into the ICSP SIX/REGOUT
// instruction stream and streams the returned words to the host with backpressure.
module pic24_read_seq #(
    parameter int unsigned TIMEOUT    = 65535,
    parameter logic [23:0] OP_NOP     = 24'h000000,
    parameter logic [23:0] OP_GOTO200 = 24'h040200,
    parameter logic [23:0] OP_TBLPAG  = 24'h880190,
    parameter logic [23:0] OP_TBLRDL  = 24'hBA03B6,
    parameter logic [23:0] OP_VISI    = 24'h883C27
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [23:0] e_instr,
    output logic        e_cmd,
    output logic        e_valid,
    input  logic        e_ready,
    input  logic        e_dvalid,
    input  logic [15:0] e_dout
);
    typedef enum logic [2:0] {
        S_IDLE, S_PROLOG, S_LOADPTR, S_READ, S_REGOUT, S_OUTPUT, S_DONE, S_ERR
    } state_t;
    typedef enum logic [1:0] {P_ISSUE, P_WLOW, P_WHIGH} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [2:0]  step, step_n;
    logic [31:0] tmo, tmo_n;
    logic [23:0] cur_addr, cur_addr_n;
    logic [15:0] left, left_n;
    logic        prolog_done, prolog_done_n;
    logic        busy_n, done_n, err_n, rd_valid_n, e_valid_n, e_cmd_n;
    logic [15:0] rd_data_n;
    logic [23:0] e_instr_n;

    logic [23:0] cmd_instr;
    logic        cmd_regout;
    logic [2:0]  last_step;
    logic [23:0] addr_inc;

    // Instruction selected by the current group and step within it.
    always_comb begin
        cmd_instr  = OP_NOP;
        cmd_regout = 1'b0;
        last_step  = 3'd0;
        case (state)
            S_PROLOG: begin
                last_step = 3'd2;
                if (step == 3'd1) cmd_instr = OP_GOTO200;
            end
            S_LOADPTR: begin
                last_step = 3'd2;
                case (step)
                    3'd0:    cmd_instr = {4'h2, 8'h00, cur_addr[23:16], 4'h0};
                    3'd1:    cmd_instr = OP_TBLPAG;
                    default: cmd_instr = {4'h2, cur_addr[15:0], 4'h6};
                endcase
            end
            S_READ: begin
                last_step = 3'd4;
                case (step)
                    3'd0:    cmd_instr = OP_TBLRDL;
                    3'd3:    cmd_instr = OP_VISI;
                    default: cmd_instr = OP_NOP;
                endcase
            end
            S_REGOUT: begin
                cmd_regout = 1'b1;
                cmd_instr  = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n       = state;
        phase_n       = phase;
        step_n        = step;
        tmo_n         = tmo;
        cur_addr_n    = cur_addr;
        left_n        = left;
        prolog_done_n = prolog_done;
        busy_n        = busy;
        done_n        = 1'b0;
        err_n         = 1'b0;
        rd_valid_n    = rd_valid;
        rd_data_n     = rd_data;
        e_valid_n     = 1'b0;
        e_cmd_n       = e_cmd;
        e_instr_n     = e_instr;
        addr_inc      = cur_addr + 24'd2;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        busy_n     = 1'b1;
                        cur_addr_n = addr & 24'hFFFFFE;
                        left_n     = count;
                        state_n    = prolog_done ? S_LOADPTR : S_PROLOG;
                        step_n     = '0;
                        phase_n    = P_ISSUE;
                        tmo_n      = '0;
                    end
                end
            end
            S_PROLOG, S_LOADPTR, S_READ, S_REGOUT: begin
                tmo_n = tmo + 32'd1;
                case (phase)
                    P_ISSUE: begin
                        if (e_ready) begin
                            e_valid_n = 1'b1;
                            e_instr_n = cmd_instr;
                            e_cmd_n   = cmd_regout;
                            phase_n   = P_WLOW;
                            tmo_n     = '0;
                        end
                    end
                    P_WLOW: begin
                        if (!e_ready) begin
                            phase_n = P_WHIGH;
                            tmo_n   = '0;
                        end
                    end
                    default: begin
                        if (cmd_regout && e_dvalid) rd_data_n = e_dout;
                        if (e_ready) begin
                            phase_n = P_ISSUE;
                            tmo_n   = '0;
                            if (step == last_step) begin
                                step_n = '0;
                                case (state)
                                    S_PROLOG: begin
                                        prolog_done_n = 1'b1;
                                        state_n       = S_LOADPTR;
                                    end
                                    S_LOADPTR: state_n = S_READ;
                                    S_READ:    state_n = S_REGOUT;
                                    default: begin
                                        state_n    = S_OUTPUT;
                                        rd_valid_n = 1'b1;
                                    end
                                endcase
                            end else begin
                                step_n = step + 3'd1;
                            end
                        end
                    end
                endcase
                // Abort only when this cycle makes no progress and the wait budget is spent.
                if (phase_n == phase && tmo == TIMEOUT - 1) state_n = S_ERR;
            end
            S_OUTPUT: begin
                if (rd_ready) begin
                    rd_valid_n = 1'b0;
                    left_n     = left - 16'd1;
                    cur_addr_n = addr_inc;
                    step_n     = '0;
                    phase_n    = P_ISSUE;
                    tmo_n      = '0;
                    if (left == 16'd1)             state_n = S_DONE;
                    else if (addr_inc[15:0] == '0) state_n = S_LOADPTR;
                    else                           state_n = S_READ;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            S_ERR: begin
                err_n         = 1'b1;
                busy_n        = 1'b0;
                prolog_done_n = 1'b0;
                state_n       = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            phase       <= P_ISSUE;
            step        <= '0;
            tmo         <= '0;
            cur_addr    <= '0;
            left        <= '0;
            prolog_done <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            e_valid     <= 1'b0;
            e_cmd       <= 1'b0;
            e_instr     <= '0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            step        <= step_n;
            tmo         <= tmo_n;
            cur_addr    <= cur_addr_n;
            left        <= left_n;
            prolog_done <= prolog_done_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
            rd_valid    <= rd_valid_n;
            rd_data     <= rd_data_n;
            e_valid     <= e_valid_n;
            e_cmd       <= e_cmd_n;
            e_instr     <= e_instr_n;
        end
    end
endmodule

// File: tb/tb_pic24_read_seq.sv
// Bench for pic24_read_seq: ICSP engine model with 50-clock busy time, command and
// data scoreboards, directed scenarios for prolog, page crossing, stall, timeout, reset.
module tb_pic24_read_seq;
    logic        clk = 1'b0;
    logic        rstn, start, rd_ready;
    logic [23:0] addr;
    logic [15:0] count;
    logic        busy, done, err, rd_valid;
    logic [15:0] rd_data;
    logic [23:0] e_instr;
    logic        e_cmd, e_valid, e_ready, e_dvalid;
    logic [15:0] e_dout;

    int compared = 0;
    int mismatched = 0;

    logic [24:0] exp_q[$];
    logic [24:0] obs_q[$];
    logic [15:0] exp_data[$];

    logic        eng_stall = 1'b0;
    logic        eng_kick = 1'b0;
    logic        eng_rstn;
    int          eng_cnt;
    logic        eng_regout;
    logic [15:0] word_seed = 16'h1234;
    logic        ev_prev = 1'b0;
    int          n_valid = 0, n_done = 0, n_err = 0, proto_bad = 0;

    always #5 clk = ~clk;

    pic24_read_seq #(.TIMEOUT(100)) dut (
        .clk(clk), .rstn(rstn), .start(start), .addr(addr), .count(count),
        .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .e_instr(e_instr), .e_cmd(e_cmd), .e_valid(e_valid), .e_ready(e_ready),
        .e_dvalid(e_dvalid), .e_dout(e_dout)
    );

    assign eng_rstn = rstn & ~eng_kick;

    // Engine model: accepts on valid&ready, busy 50 clocks, REGOUT returns a fresh word.
    always @(posedge clk or negedge eng_rstn) begin
        if (!eng_rstn) begin
            e_ready    <= 1'b1;
            e_dvalid   <= 1'b0;
            e_dout     <= '0;
            eng_cnt    <= 0;
            eng_regout <= 1'b0;
        end else begin
            e_dvalid <= 1'b0;
            if (e_ready && e_valid) begin
                obs_q.push_back({e_cmd, e_instr});
                e_ready    <= 1'b0;
                eng_cnt    <= 50;
                eng_regout <= e_cmd;
            end else if (!e_ready && !eng_stall) begin
                if (eng_cnt <= 1) begin
                    e_ready <= 1'b1;
                    if (eng_regout) begin
                        e_dvalid  <= 1'b1;
                        e_dout    <= word_seed;
                        exp_data.push_back(word_seed);
                        word_seed <= word_seed + 16'h1111;
                    end
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (e_valid) n_valid++;
        if (done) n_done++;
        if (err) n_err++;
        if (e_valid && (!e_ready || ev_prev)) proto_bad++;
        ev_prev <= e_valid;
    end

    function automatic logic [24:0] mk(input logic r, input logic [23:0] i);
        return {r, i};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_prolog();
        exp_q.push_back(mk(1'b0, 24'h000000));
        exp_q.push_back(mk(1'b0, 24'h040200));
        exp_q.push_back(mk(1'b0, 24'h000000));
    endtask

    task automatic push_loadptr(input logic [23:0] w0, input logic [23:0] w6);
        exp_q.push_back(mk(1'b0, w0));
        exp_q.push_back(mk(1'b0, 24'h880190));
        exp_q.push_back(mk(1'b0, w6));
    endtask

    task automatic push_read();
        exp_q.push_back(mk(1'b0, 24'hBA03B6));
        exp_q.push_back(mk(1'b0, 24'h000000));
        exp_q.push_back(mk(1'b0, 24'h000000));
        exp_q.push_back(mk(1'b0, 24'h883C27));
        exp_q.push_back(mk(1'b0, 24'h000000));
        exp_q.push_back(mk(1'b1, 24'h000000));
    endtask

    task automatic request(input logic [23:0] a, input logic [15:0] c);
        addr  = a;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_e_valid"}, e_valid, 0);
        chk({tag, "_e_cmd"}, e_cmd, 0);
        chk({tag, "_e_instr"}, e_instr, 0);
    endtask

    task automatic host_read(input string tag, input int n, input bit hold);
        for (int w = 0; w < n; w++) begin
            int t;
            logic [15:0] expd;
            t = 0;
            while (!rd_valid && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk({tag, "_rd_valid"}, rd_valid, 1);
            expd = (exp_data.size() > 0) ? exp_data.pop_front() : 16'hxxxx;
            chk({tag, "_rd_data"}, rd_data, expd);
            if (hold) begin
                int nv, bad;
                logic [15:0] d0;
                nv  = n_valid;
                bad = 0;
                d0  = rd_data;
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (rd_valid !== 1'b1 || rd_data !== d0 || err !== 1'b0) bad++;
                end
                chk({tag, "_hold_stable"}, bad, 0);
                chk({tag, "_hold_no_cmd"}, n_valid, nv);
            end
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            chk({tag, "_rd_valid_drop"}, rd_valid, 0);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic check_cmds(input string tag);
        logic [24:0] o;
        chk({tag, "_ncmd"}, obs_q.size(), exp_q.size());
        for (int i = 0; exp_q.size() > 0; i++) begin
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 25'bx;
            chk($sformatf("%s_cmd%0d", tag, i), o, exp_q.pop_front());
        end
        obs_q.delete();
    endtask

    initial begin
        int nv0, nd0, ne0, t, lat;
        rstn = 1'b1; start = 1'b0; addr = '0; count = '0; rd_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // First request: prolog, pointer load, two sequential words; a start while busy is ignored.
        push_prolog();
        push_loadptr(24'h200000, 24'h202006);
        push_read();
        push_read();
        request(24'h000200, 16'd2);
        chk("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        request(24'h001000, 16'd5);
        host_read("t1", 2, 1'b0);
        wait_done("t1");
        check_cmds("t1");

        // Page crossing: second word reloads TBLPAG with 0x01 and W6 with 0x0000.
        push_loadptr(24'h200000, 24'h2FFFE6);
        push_read();
        push_loadptr(24'h200010, 24'h200006);
        push_read();
        request(24'h00FFFE, 16'd2);
        host_read("t2", 2, 1'b0);
        wait_done("t2");
        check_cmds("t2");

        // Zero-length request.
        nv0 = n_valid;
        request(24'h000300, 16'd0);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        @(negedge clk);
        chk("t3_done_pulse", done, 0);
        repeat (5) @(negedge clk);
        chk("t3_no_cmd", n_valid, nv0);

        // Host stall on the word; odd address treated as even.
        ne0 = n_err;
        push_loadptr(24'h200000, 24'h204006);
        push_read();
        request(24'h000401, 16'd1);
        host_read("t4", 1, 1'b1);
        wait_done("t4");
        check_cmds("t4");
        chk("t4_no_err", n_err, ne0);

        // Engine stops answering after the first command.
        eng_stall = 1'b1;
        ne0 = n_err;
        nd0 = n_done;
        exp_q.push_back(mk(1'b0, 24'h200000));
        request(24'h000600, 16'd1);
        t = 0;
        while (e_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        lat = 0;
        while (!err && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_err_latency_in_100_102", (lat >= 100 && lat <= 102), 1);
        @(negedge clk);
        chk("t5_err_pulse", err, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_done", n_done, nd0);
        chk("t5_one_err", n_err, ne0 + 1);
        check_cmds("t5");
        eng_stall = 1'b0;
        eng_kick  = 1'b1;
        @(negedge clk);
        eng_kick  = 1'b0;
        exp_data.delete();
        push_prolog();
        push_loadptr(24'h200000, 24'h208006);
        push_read();
        request(24'h000800, 16'd1);
        host_read("t5b", 1, 1'b0);
        wait_done("t5b");
        check_cmds("t5b");

        // Asynchronous reset while REGOUT is in flight.
        request(24'h000A00, 16'd1);
        t = 0;
        while (!(e_cmd && !e_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("t6_in_regout", e_cmd, 1);
        nd0 = n_done;
        ne0 = n_err;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_done", n_done, nd0);
        chk("t6_no_err", n_err, ne0);
        obs_q.delete();
        exp_q.delete();
        exp_data.delete();
        push_prolog();
        push_loadptr(24'h200000, 24'h20A006);
        push_read();
        request(24'h000A00, 16'd1);
        host_read("t6b", 1, 1'b0);
        wait_done("t6b");
        check_cmds("t6b");

        chk("protocol", proto_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
